rgb_byte_assembler: RTL

RGB_BYTE_ASSEMBLER -- requirements
Module: rgb_byte_assembler

---
 rtl/img_pkg.sv | 16 +
 rtl/pixel_xy_counter.sv | 41 ++++
 rtl/rgb_byte_assembler.sv | 107 ++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared image-pipeline definitions: byte phase encoding, default frame geometry, pixel width.
package img_pkg;

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_t;

  localparam int DEF_IMG_WIDTH  = 64;
  localparam int DEF_IMG_HEIGHT = 64;
  localparam int PIX_W          = 8;
  // Wide enough for the largest supported geometry (4096).
  localparam int CNT_W          = 12;

endpackage

// File: rtl/pixel_xy_counter.sv
// Column/line position counters with wrap; flags describe the pixel at the current position.
module pixel_xy_counter
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic advance,
  output logic sof,
  output logic eol,
  output logic eof
);

  localparam logic [CNT_W-1:0] LAST_X = CNT_W'(IMG_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_Y = CNT_W'(IMG_HEIGHT - 1);

  logic [CNT_W-1:0] x;
  logic [CNT_W-1:0] y;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == LAST_X) begin
        x <= '0;
        y <= (y == LAST_Y) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign sof = (x == '0) && (y == '0);
  assign eol = (x == LAST_X);
  assign eof = eol && (y == LAST_Y);

endmodule

// File: rtl/rgb_byte_assembler.sv
// Packs an R,G,B byte stream into pixels held in a single-entry output register with position flags.
module rgb_byte_assembler
  import img_pkg::*;
#(
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int IMG_HEIGHT = DEF_IMG_HEIGHT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  input  logic             frame_start,
  output logic [PIX_W-1:0] r_out,
  output logic [PIX_W-1:0] g_out,
  output logic [PIX_W-1:0] b_out,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             sof,
  output logic             eol,
  output logic             eof,
  output logic [15:0]      frame_count
);

  phase_t           phase;
  logic [PIX_W-1:0] r_hold;
  logic [PIX_W-1:0] g_hold;
  logic             accept;
  logic             load;
  logic             handshake;
  logic             pos_sof;
  logic             pos_eol;
  logic             pos_eof;

  // Only a B byte needs the output register, so stall just that phase.
  assign byte_ready = !((phase == PH_B) && pix_valid && !pix_ready);
  assign accept     = byte_valid && byte_ready;
  assign load       = accept && (phase == PH_B) && !frame_start;
  assign handshake  = pix_valid && pix_ready;

  pixel_xy_counter #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT)
  ) u_xy (
    .clk    (clk),
    .rst    (rst),
    .clear  (frame_start),
    .advance(load),
    .sof    (pos_sof),
    .eol    (pos_eol),
    .eof    (pos_eof)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      phase       <= PH_R;
      r_hold      <= '0;
      g_hold      <= '0;
      r_out       <= '0;
      g_out       <= '0;
      b_out       <= '0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      eof         <= 1'b0;
      pix_valid   <= 1'b0;
      frame_count <= '0;
    end else begin
      if (handshake && eof)
        frame_count <= frame_count + 16'd1;

      if (frame_start) begin
        // A byte arriving with the resync pulse is R of pixel (0,0).
        if (accept) begin
          r_hold <= byte_in;
          phase  <= PH_G;
        end else begin
          phase  <= PH_R;
        end
      end else if (accept) begin
        case (phase)
          PH_R: begin
            r_hold <= byte_in;
            phase  <= PH_G;
          end
          PH_G: begin
            g_hold <= byte_in;
            phase  <= PH_B;
          end
          default: phase <= PH_R;
        endcase
      end

      if (load) begin
        r_out     <= r_hold;
        g_out     <= g_hold;
        b_out     <= byte_in;
        sof       <= pos_sof;
        eol       <= pos_eol;
        eof       <= pos_eof;
        pix_valid <= 1'b1;
      end else if (handshake) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule
